bus_arbiter_n: RTL and testbench
================================

// Module: bus_arbiter_n
// PURPOSE
//  N-master system-bus arbiter, parametrised successor to the 2-master arbiter.
//  Grants the shared bus to one master under fixed-priority or round-robin
//  policy, then shifts in a serial slave address from the granted master.
//  Drives the slave-select fabric. Enforces a bounded bus tenure via hold timeout.
// PARAMETERS
//  NUM_MASTERS   4   requesting masters, >=2; need not be a power of two
//  SLAVE_ADDR_W  2   serial slave-address bits shifted in per transaction, >=1
//  RR_MODE       1   1 = round-robin, 0 = fixed priority (lowest index wins)
//  MAX_HOLD      16  max CONNECT cycles before forced release; 0 = unlimited
//  (localparam MW = max(1, clog2(NUM_MASTERS)))
// PORTS
//  clk             in   1             bus clock, rising edge
//  reset           in   1             asynchronous, active-high
//  m_request       in   NUM_MASTERS   per-master bus request, level, held for tenure
//  m_slave_select  in   NUM_MASTERS   per-master serial slave-address bit, MSB first
//  m_grant         out  NUM_MASTERS   one-hot grant, all-zero when idle
//  bus_grant       out  MW            index of granted master, qualified by busy
//  slave_grant     out  SLAVE_ADDR_W  decoded slave address, qualified by slave_valid
//  slave_valid     out  1             slave path connected
//  busy            out  1             bus owned (ADDR or CONNECT)
//  timeout         out  1             1-cycle pulse on forced release
// BEHAVIOUR
//  - All outputs are registered.
//  - Reset (async, mid-operation included): outputs 0 immediately, state IDLE,
//    RR pointer 0, bit counter and hold counter 0.
//  - States: IDLE -> ADDR -> CONNECT -> IDLE.
//  - IDLE:
//    - At an edge with any m_request set, pick winner -> ADDR.
//    - m_grant[winner], bus_grant = winner and busy become visible 1 cycle after
//      the sampling edge. Latency 1.
//  - Winner selection:
//    - RR_MODE=0: lowest set index wins.
//    - RR_MODE=1: first set index at or after ptr, wrapping NUM_MASTERS-1 -> 0.
//      ptr = winner+1 (mod NUM_MASTERS), updated when the tenure ends.
//  - ADDR:
//    - Each of the next SLAVE_ADDR_W edges shifts m_slave_select[winner] into the
//      address register, MSB first.
//    - At the last bit edge: slave_grant loads, slave_valid=1, -> CONNECT.
//      Example: grant at edge E1, bits sampled at E2..E(1+SLAVE_ADDR_W), slave_valid
//      visible after E(1+SLAVE_ADDR_W).
//    - If m_request[winner] is sampled 0 during ADDR: abort -> IDLE, slave_valid
//      never asserts, no timeout, ptr still advances.
//  - CONNECT:
//    - Hold counter counts cycles of slave_valid.
//    - m_request[winner] sampled 0 -> IDLE. m_grant, busy, slave_valid,
//      slave_grant and bus_grant all clear on that edge.
//    - MAX_HOLD>0 and slave_valid has been high MAX_HOLD cycles -> forced release
//      -> IDLE. Outputs clear on that edge; timeout=1 for exactly that next cycle.
//    - If the request drops on the same edge as the timeout would fire:
//      normal release, timeout stays 0.
//  - After every tenure, IDLE lasts >=1 cycle (busy=0). No back-to-back grants.
//  - No preemption: requests from other masters are ignored while busy.
//  - The new winner is chosen only in IDLE from the current request vector.
//  - A master still requesting after forced release re-competes normally.
//  - Under RR it ranks last.
// TESTING  (NUM_MASTERS=4, SLAVE_ADDR_W=2, RR_MODE=1, MAX_HOLD=8)
//  - Reset: hold reset, toggle inputs -> all outputs 0. Release, m_request=0 ->
//    outputs stay 0.
//  - Single master: m_request=4'b0001, serial bits 1,0 -> m_grant=0001 and busy
//    after 1 edge. slave_grant=2'b10 and slave_valid after 3 edges. Drop request
//    -> all outputs 0 next cycle.
//  - Round-robin: m_request=4'b1111, each master drops 2 cycles into CONNECT ->
//    bus_grant sequence 0,1,2,3,0, with busy=0 for 1 cycle between tenures.
//    Repeat with RR_MODE=0 -> always 0.
//  - Timeout: m_request=4'b0100 held -> slave_valid high exactly 8 cycles, then
//    timeout=1 for 1 cycle and m_grant=0. Re-grant to master 2 after the 1-cycle gap.
//  - Abort and async reset:
//    - Master 1 drops its request after 1 address bit -> slave_valid never 1,
//      busy clears next cycle.
//    - Assert reset between edges mid-CONNECT -> outputs 0 before the next edge.
//      After release with m_request=4'b1111 -> master 0 granted, proving ptr was reset.

Source files
------------

// File: rtl/bus_arbiter_n.sv
// bus_arbiter_n: N-master system-bus arbiter. Grants the bus under fixed-priority
// or round-robin policy, shifts in a serial slave address from the winner, then
// holds the slave connection until the winner releases or the hold limit expires.
module bus_arbiter_n #(
    parameter int unsigned NUM_MASTERS  = 4,
    parameter int unsigned SLAVE_ADDR_W = 2,
    parameter int unsigned RR_MODE      = 1,
    parameter int unsigned MAX_HOLD     = 16,
    localparam int unsigned MW = (NUM_MASTERS > 2) ? $clog2(NUM_MASTERS) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_MASTERS-1:0]  m_request,
    input  logic [NUM_MASTERS-1:0]  m_slave_select,
    output logic [NUM_MASTERS-1:0]  m_grant,
    output logic [MW-1:0]           bus_grant,
    output logic [SLAVE_ADDR_W-1:0] slave_grant,
    output logic                    slave_valid,
    output logic                    busy,
    output logic                    timeout
);

    // Bit counter runs 0..SLAVE_ADDR_W-1, hold counter 0..MAX_HOLD-1.
    localparam int unsigned BCW = (SLAVE_ADDR_W > 1) ? $clog2(SLAVE_ADDR_W) : 1;
    localparam int unsigned HCW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

    typedef enum logic [1:0] {StIdle, StAddr, StConnect} state_e;

    state_e                  state_q;
    logic [MW-1:0]           win_q;
    logic [MW-1:0]           ptr_q;
    logic [BCW-1:0]          bit_cnt_q;
    logic [HCW-1:0]          hold_cnt_q;
    logic [SLAVE_ADDR_W-1:0] addr_q;

    logic [MW-1:0]           base;
    logic [NUM_MASTERS-1:0]  hi_req;
    logic [MW-1:0]           winner;
    logic                    any_req;
    logic                    win_req;
    logic                    win_sel;
    logic                    hold_expired;
    logic                    last_bit;
    logic                    end_tenure;
    logic                    forced;
    logic [SLAVE_ADDR_W-1:0] addr_next;
    logic [MW-1:0]           ptr_next;

    // Winner selection: lowest requester at or above base, else lowest overall (wrap).
    always_comb begin
        base    = (RR_MODE != 0) ? ptr_q : '0;
        any_req = |m_request;
        hi_req  = '0;
        winner  = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            hi_req[i] = m_request[i] && (i >= int'(base));
        end
        // Descending overwrite leaves the lowest matching index in winner.
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            if (m_request[i]) winner = MW'(i);
        end
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            if (hi_req[i]) winner = MW'(i);
        end
    end

    // Request and serial address bit of the current bus owner.
    always_comb begin
        win_req = 1'b0;
        win_sel = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (win_q == MW'(i)) begin
                win_req = m_request[i];
                win_sel = m_slave_select[i];
            end
        end
    end

    // Tenure termination: a dropped request wins over a simultaneous hold expiry.
    always_comb begin
        hold_expired = (MAX_HOLD != 0) && (hold_cnt_q == HCW'(MAX_HOLD - 1));
        last_bit     = (bit_cnt_q == BCW'(SLAVE_ADDR_W - 1));
        addr_next    = SLAVE_ADDR_W'({addr_q, win_sel});
        ptr_next     = (win_q == MW'(NUM_MASTERS - 1)) ? '0 : win_q + 1'b1;
        end_tenure   = 1'b0;
        forced       = 1'b0;
        if (state_q == StAddr) begin
            end_tenure = !win_req;
        end else if (state_q == StConnect) begin
            end_tenure = !win_req || hold_expired;
            forced     = win_req && hold_expired;
        end
    end

    // Arbitration FSM with registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            win_q       <= '0;
            ptr_q       <= '0;
            bit_cnt_q   <= '0;
            hold_cnt_q  <= '0;
            addr_q      <= '0;
            m_grant     <= '0;
            bus_grant   <= '0;
            slave_grant <= '0;
            slave_valid <= 1'b0;
            busy        <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            timeout <= 1'b0;
            if (end_tenure) begin
                // Release always passes through IDLE, so grants are never back-to-back.
                state_q     <= StIdle;
                ptr_q       <= ptr_next;
                bit_cnt_q   <= '0;
                hold_cnt_q  <= '0;
                m_grant     <= '0;
                bus_grant   <= '0;
                slave_grant <= '0;
                slave_valid <= 1'b0;
                busy        <= 1'b0;
                timeout     <= forced;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (any_req) begin
                            state_q   <= StAddr;
                            win_q     <= winner;
                            bus_grant <= winner;
                            m_grant   <= {{(NUM_MASTERS - 1){1'b0}}, 1'b1} << winner;
                            busy      <= 1'b1;
                            bit_cnt_q <= '0;
                        end
                    end
                    StAddr: begin
                        addr_q <= addr_next;
                        if (last_bit) begin
                            state_q     <= StConnect;
                            slave_grant <= addr_next;
                            slave_valid <= 1'b1;
                            hold_cnt_q  <= '0;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end
                    StConnect: begin
                        hold_cnt_q <= hold_cnt_q + 1'b1;
                    end
                    default: begin
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bus_arbiter_n.sv
// tb_bus_arbiter_n: directed and random checks of bus_arbiter_n, one round-robin and
// one fixed-priority instance, against a tenure-level reference model.
module tb_bus_arbiter_n;

    localparam int W    = 2;
    localparam int HOLD = 8;

    logic       clk;
    logic       reset;
    logic [3:0] req   [2];
    logic [3:0] sel   [2];
    logic [3:0] gnt   [2];
    logic [1:0] bg    [2];
    logic [1:0] sg    [2];
    logic       vld   [2];
    logic       busy  [2];
    logic       tmo_o [2];

    int total = 0;
    int bad   = 0;

    // Reference model: owner (-1 = idle), edges since grant, captured address, RR pointer.
    int owner [2];
    int age   [2];
    int addr  [2];
    int ptr   [2];
    bit tmo_m [2];
    int seen  [$];

    bus_arbiter_n #(.NUM_MASTERS(4), .SLAVE_ADDR_W(W), .RR_MODE(1), .MAX_HOLD(HOLD)) dut_rr (
        .clk(clk), .reset(reset), .m_request(req[0]), .m_slave_select(sel[0]),
        .m_grant(gnt[0]), .bus_grant(bg[0]), .slave_grant(sg[0]), .slave_valid(vld[0]),
        .busy(busy[0]), .timeout(tmo_o[0])
    );

    bus_arbiter_n #(.NUM_MASTERS(4), .SLAVE_ADDR_W(W), .RR_MODE(0), .MAX_HOLD(HOLD)) dut_fp (
        .clk(clk), .reset(reset), .m_request(req[1]), .m_slave_select(sel[1]),
        .m_grant(gnt[1]), .bus_grant(bg[1]), .slave_grant(sg[1]), .slave_valid(vld[1]),
        .busy(busy[1]), .timeout(tmo_o[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset(int k);
        owner[k] = -1;
        age[k]   = 0;
        addr[k]  = 0;
        ptr[k]   = 0;
        tmo_m[k] = 1'b0;
    endtask

    // Instance 0 is round-robin, instance 1 fixed priority.
    function automatic int pick(int k);
        int base;
        int m;
        base = (k == 0) ? ptr[k] : 0;
        for (int i = 0; i < 4; i++) begin
            m = (base + i) % 4;
            if (((req[k] >> m) & 4'd1) != 4'd0) return m;
        end
        return -1;
    endfunction

    task automatic finish_tenure(int k);
        ptr[k]   = (owner[k] + 1) % 4;
        owner[k] = -1;
    endtask

    task automatic model_step(int k);
        int w;
        tmo_m[k] = 1'b0;
        if (owner[k] < 0) begin
            w = pick(k);
            if (w >= 0) begin
                owner[k] = w;
                age[k]   = 0;
                addr[k]  = 0;
            end
        end else begin
            age[k]++;
            if (((req[k] >> owner[k]) & 4'd1) == 4'd0) begin
                finish_tenure(k);
            end else if (age[k] <= W) begin
                addr[k] = addr[k] * 2 + int'((sel[k] >> owner[k]) & 4'd1);
            end else if (age[k] - W == HOLD) begin
                finish_tenure(k);
                tmo_m[k] = 1'b1;
            end
        end
    endtask

    task automatic check(int k);
        logic [3:0] eg;
        logic [1:0] eb;
        logic       ev;
        logic [1:0] es;
        eg = (owner[k] >= 0) ? 4'(1 << owner[k]) : 4'd0;
        eb = (owner[k] >= 0) ? 2'(owner[k]) : 2'd0;
        ev = (owner[k] >= 0) && (age[k] >= W);
        es = ev ? 2'(addr[k]) : 2'd0;
        chk($sformatf("m_grant[%0d]", k), 32'(gnt[k]), 32'(eg));
        chk($sformatf("bus_grant[%0d]", k), 32'(bg[k]), 32'(eb));
        chk($sformatf("busy[%0d]", k), 32'(busy[k]), 32'(owner[k] >= 0));
        chk($sformatf("slave_valid[%0d]", k), 32'(vld[k]), 32'(ev));
        chk($sformatf("slave_grant[%0d]", k), 32'(sg[k]), 32'(es));
        chk($sformatf("timeout[%0d]", k), 32'(tmo_o[k]), 32'(tmo_m[k]));
    endtask

    // One clock edge: advance the model with the inputs the DUT samples, then compare.
    task automatic tick();
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (reset) model_reset(k);
            else model_step(k);
        end
        #1;
        for (int k = 0; k < 2; k++) check(k);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // All four masters request; the owner drops two cycles into CONNECT and re-requests
    // right after release. Records the granted index of each of n tenures.
    task automatic run_drop(int k, int n);
        int got;
        int idle;
        int cyc;
        got  = 0;
        idle = 0;
        cyc  = 0;
        seen.delete();
        req[k] = 4'hF;
        while (got < n && cyc < 200) begin
            tick();
            cyc++;
            if (owner[k] >= 0 && age[k] == 0) begin
                seen.push_back(int'(bg[k]));
                if (got > 0) chk($sformatf("rr_gap[%0d]", k), 32'(idle), 32'd1);
                got++;
                idle = 0;
            end else if (owner[k] < 0) begin
                idle++;
            end
            if (owner[k] >= 0 && age[k] == W + 1) req[k] = req[k] & ~(4'd1 << owner[k]);
            if (owner[k] < 0) req[k] = 4'hF;
        end
        chk($sformatf("rr_bound[%0d]", k), 32'(got), 32'(n));
        req[k] = 4'h0;
        repeat (2) tick();
    endtask

    initial begin
        int cnt;
        int cyc;
        int obs;
        bit saw_valid;
        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            req[k] = 4'h0;
            sel[k] = 4'h0;
            model_reset(k);
        end

        // Reset held while inputs toggle, then released with no requests.
        repeat (4) begin
            for (int k = 0; k < 2; k++) begin
                req[k] = 4'($urandom);
                sel[k] = 4'($urandom);
            end
            tick();
        end
        for (int k = 0; k < 2; k++) begin
            req[k] = 4'h0;
            sel[k] = 4'h0;
        end
        reset = 1'b0;
        repeat (3) tick();

        // Single master 0, address bits 1 then 0.
        req[0] = 4'b0001;
        sel[0] = 4'b0001;
        tick();
        chk("single_grant", 32'(gnt[0]), 32'h1);
        chk("single_busy", 32'(busy[0]), 32'h1);
        tick();
        sel[0] = 4'b0000;
        tick();
        chk("single_addr", 32'(sg[0]), 32'h2);
        chk("single_valid", 32'(vld[0]), 32'h1);
        tick();
        req[0] = 4'b0000;
        tick();
        chk("single_release", 32'({gnt[0], busy[0], vld[0], sg[0]}), 32'h0);
        tick();

        // Round-robin rotation and fixed-priority starvation.
        do_reset();
        run_drop(0, 5);
        for (int i = 0; i < 5; i++) begin
            obs = (i < seen.size()) ? seen[i] : -1;
            chk($sformatf("rr_seq%0d", i), 32'(obs), 32'(i % 4));
        end
        run_drop(1, 5);
        for (int i = 0; i < 5; i++) begin
            obs = (i < seen.size()) ? seen[i] : -1;
            chk($sformatf("fp_seq%0d", i), 32'(obs), 32'd0);
        end

        // Hold timeout on master 2, then re-grant after one idle cycle.
        req[0] = 4'b0100;
        cnt = 0;
        cyc = 0;
        while (tmo_o[0] !== 1'b1 && cyc < 40) begin
            sel[0] = 4'($urandom);
            tick();
            cyc++;
            if (vld[0] === 1'b1) cnt++;
        end
        chk("tmo_valid_cycles", 32'(cnt), 32'd8);
        chk("tmo_pulse", 32'(tmo_o[0]), 32'h1);
        chk("tmo_grant_clear", 32'(gnt[0]), 32'h0);
        tick();
        chk("tmo_regrant", 32'(gnt[0]), 32'h4);
        chk("tmo_one_cycle", 32'(tmo_o[0]), 32'h0);
        req[0] = 4'b0000;
        repeat (2) tick();

        // Abort in ADDR: master 1 drops after one address bit.
        req[0] = 4'b0010;
        sel[0] = 4'b0010;
        saw_valid = 1'b0;
        tick();
        tick();
        if (vld[0] === 1'b1) saw_valid = 1'b1;
        req[0] = 4'b0000;
        tick();
        if (vld[0] === 1'b1) saw_valid = 1'b1;
        chk("abort_busy", 32'(busy[0]), 32'h0);
        chk("abort_no_valid", 32'(saw_valid), 32'h0);
        tick();

        // Async reset between edges mid-CONNECT, then pointer restarts at 0.
        req[0] = 4'hF;
        cyc = 0;
        while (vld[0] !== 1'b1 && cyc < 10) begin
            tick();
            cyc++;
        end
        chk("areset_connect", 32'(vld[0]), 32'h1);
        tick();
        #3;
        reset = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) model_reset(k);
        for (int k = 0; k < 2; k++) check(k);
        chk("areset_busy", 32'(busy[0]), 32'h0);
        tick();
        reset = 1'b0;
        tick();
        chk("areset_ptr_grant", 32'(gnt[0]), 32'h1);
        chk("areset_ptr_index", 32'(bg[0]), 32'h0);
        req[0] = 4'h0;
        repeat (2) tick();

        // Random traffic: sticky requests with occasional flips, random address bits.
        repeat (600) begin
            for (int k = 0; k < 2; k++) begin
                for (int b = 0; b < 4; b++) begin
                    if ($urandom_range(9) == 0) req[k][b] = ~req[k][b];
                end
                sel[k] = 4'($urandom);
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
